// File: rtl/rom_frame_streamer.sv
// rom_frame_streamer
//   Streams one IMG_W x IMG_H frame out of a synchronous ROM, one fetch per
//   pix_en cycle, and presents each pixel with its coordinates once the ROM
//   data returns ROM_LAT cycles later.
//
// Optional feature: define ROM_FRAME_STREAMER_LOOP_EN to replay frames back to
//   back. base_addr is re-sampled on the last fetch, and the block stays in RUN.
//   Without it, the block returns to IDLE after each frame.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   start                one-cycle frame request (aborts a running frame)
//   pix_en               fetch strobe
//   base_addr            ROM address of pixel (0,0), sampled when start is taken
//   rom_addr, rom_data   ROM read port (rom_data packed {r,g,b})
//   r, g, b              registered pixel colour
//   pix_x, pix_y         coordinates of the pixel on r/g/b
//   pix_valid            r/g/b/pix_x/pix_y carry a new pixel this cycle
//   busy                 high while in RUN
//   frame_done           pulses with pix_valid of the last pixel of a frame
module rom_frame_streamer #(
  parameter int IMG_W   = 800,
  parameter int IMG_H   = 600,
  parameter int ADDR_W  = 19,
  parameter int CH_W    = 4,
  parameter int ROM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pix_en,
  input  logic [ADDR_W-1:0] base_addr,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [3*CH_W-1:0] rom_data,
  output logic [CH_W-1:0]   r,
  output logic [CH_W-1:0]   g,
  output logic [CH_W-1:0]   b,
  output logic [15:0]       pix_x,
  output logic [15:0]       pix_y,
  output logic              pix_valid,
  output logic              busy,
  output logic              frame_done
);

  localparam logic [15:0]       X_LAST = 16'(IMG_W - 1);
  localparam logic [15:0]       Y_LAST = 16'(IMG_H - 1);
  localparam logic [ADDR_W-1:0] ONE    = ADDR_W'(1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t                     state;
  logic [15:0]                x, y;
  logic [ROM_LAT-1:0]         vld_pipe;
  logic [ROM_LAT-1:0]         last_pipe;
  logic [ROM_LAT-1:0][15:0]   x_pipe, y_pipe;

  // start wins over pix_en: a start cycle only (re)loads the frame.
  logic fetch, at_end;
  assign fetch  = (state == RUN) && pix_en && !start;
  assign at_end = (x == X_LAST) && (y == Y_LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      busy       <= 1'b0;
      x          <= '0;
      y          <= '0;
      rom_addr   <= '0;
      vld_pipe   <= '0;
      last_pipe  <= '0;
      x_pipe     <= '0;
      y_pipe     <= '0;
      r          <= '0;
      g          <= '0;
      b          <= '0;
      pix_x      <= '0;
      pix_y      <= '0;
      pix_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      // Tag pipeline: stage ROM_LAT-1 lines up with rom_data of the fetch.
      vld_pipe[0]  <= fetch;
      last_pipe[0] <= fetch && at_end;
      x_pipe[0]    <= x;
      y_pipe[0]    <= y;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
        x_pipe[i]    <= x_pipe[i-1];
        y_pipe[i]    <= y_pipe[i-1];
      end

      pix_valid  <= vld_pipe[ROM_LAT-1];
      frame_done <= vld_pipe[ROM_LAT-1] && last_pipe[ROM_LAT-1];
      if (vld_pipe[ROM_LAT-1]) begin
        {r, g, b} <= rom_data;
        pix_x     <= x_pipe[ROM_LAT-1];
        pix_y     <= y_pipe[ROM_LAT-1];
      end

      case (state)
        IDLE: begin
          if (start) begin
            state    <= RUN;
            busy     <= 1'b1;
            x        <= '0;
            y        <= '0;
            rom_addr <= base_addr;
          end
        end
        RUN: begin
          if (start) begin
            x        <= '0;
            y        <= '0;
            rom_addr <= base_addr;
          end else if (pix_en) begin
            if (at_end) begin
`ifdef ROM_FRAME_STREAMER_LOOP_EN
              x        <= '0;
              y        <= '0;
              rom_addr <= base_addr;
`else
              // rom_addr deliberately holds on the last fetch.
              state    <= IDLE;
              busy     <= 1'b0;
`endif
            end else begin
              rom_addr <= rom_addr + ONE;
              if (x == X_LAST) begin
                x <= '0;
                y <= y + 16'd1;
              end else begin
                x <= x + 16'd1;
              end
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rom_frame_streamer.sv
// Bench for rom_frame_streamer: two instances (ROM_LAT=1 and ROM_LAT=2) share
// stimulus. A frame-level model (pixel index n -> addr/x/y) schedules the
// expected pixel of every fetch; a monitor compares the pixel stream, and the
// test tasks report the outcome plus scenario-specific values.
module tb_rom_frame_streamer;

  localparam int W = 4, H = 2, N = W * H, AW = 10, CW = 4;

  typedef struct {
    logic [AW-1:0] addr;
    logic [15:0]   x, y;
    bit            last;
  } pix_t;

  logic clk, rst_n, start, pix_en;
  logic [AW-1:0] base_addr;
  logic [AW-1:0] a1, a2;
  logic [3*CW-1:0] rd1, rd2a, rd2;
  logic [CW-1:0] r1, g1, b1, r2, g2, b2;
  logic [15:0] x1, y1, x2, y2;
  logic v1, v2, bz1, bz2, d1, d2;

  rom_frame_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CH_W(CW), .ROM_LAT(1)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_en(pix_en), .base_addr(base_addr),
    .rom_addr(a1), .rom_data(rd1), .r(r1), .g(g1), .b(b1), .pix_x(x1), .pix_y(y1),
    .pix_valid(v1), .busy(bz1), .frame_done(d1));

  rom_frame_streamer #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .CH_W(CW), .ROM_LAT(2)) u2 (
    .clk(clk), .rst_n(rst_n), .start(start), .pix_en(pix_en), .base_addr(base_addr),
    .rom_addr(a2), .rom_data(rd2), .r(r2), .g(g2), .b(b2), .pix_x(x2), .pix_y(y2),
    .pix_valid(v2), .busy(bz2), .frame_done(d2));

  function automatic logic [11:0] rom_f(input logic [AW-1:0] a);
    return {a, 2'b01} ^ {2'b00, a} ^ 12'hA5C;
  endfunction

  // ROM models: latency 1 and 2.
  always @(posedge clk) begin
    rd1  <= rom_f(a1);
    rd2a <= rom_f(a2);
    rd2  <= rd2a;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0][11:0]   o_rgb;
  logic [1:0][15:0]   o_x, o_y;
  logic [1:0][AW-1:0] o_a;
  logic [1:0]         o_v, o_d, o_bz;
  assign o_rgb[0] = {r1, g1, b1};
  assign o_rgb[1] = {r2, g2, b2};
  assign o_x  = {x2, x1};
  assign o_y  = {y2, y1};
  assign o_a  = {a2, a1};
  assign o_v  = {v2, v1};
  assign o_d  = {d2, d1};
  assign o_bz = {bz2, bz1};

  // Model state (written only by step)
  int            ecnt = 0;
  bit            m_run = 0;
  int            m_n = 0, m_fetch = 0;
  logic [AW-1:0] m_base = '0, m_addr = '0;
  bit            ev1 [0:8191];
  bit            ev2 [0:8191];
  bit            rst_e [0:8191];
  pix_t          ep1 [0:8191];
  pix_t          ep2 [0:8191];

  // Monitor state (written only by the monitor)
  bit          mon_on = 0;
  int          mon_bad = 0;
  int          mon_pix [2] = '{0, 0};
  int          mon_done [2] = '{0, 0};
  logic [11:0] h_rgb [2];
  logic [15:0] h_x [2], h_y [2];
  int          bad_edge = 0, bad_k = 0;
  logic [45:0] bad_act = '0, bad_exp = '0;
  bit          mv;
  pix_t        mp;

  int nchk = 0, nerr = 0;

  task automatic step(input bit rs, input bit st, input bit pe, input logic [AW-1:0] ba);
    pix_t p;
    rst_n = rs; start = st; pix_en = pe; base_addr = ba;
    @(posedge clk);
    ecnt++;
    if (!rs) begin
      m_run = 0; m_n = 0; m_addr = '0;
      rst_e[ecnt] = 1;
      for (int i = 0; i < 3; i++) begin ev1[ecnt+i] = 0; ev2[ecnt+i] = 0; end
    end else if (st) begin
      m_run = 1; m_n = 0; m_base = ba; m_addr = ba;
    end else if (m_run && pe) begin
      p.addr = AW'(m_base + m_n);
      p.x    = 16'(m_n % W);
      p.y    = 16'(m_n / W);
      p.last = (m_n == N - 1);
      ev1[ecnt+1] = 1; ep1[ecnt+1] = p;
      ev2[ecnt+2] = 1; ep2[ecnt+2] = p;
      m_fetch++;
      m_n++;
      if (m_n == N) begin
`ifdef ROM_FRAME_STREAMER_LOOP_EN
        m_n = 0; m_base = ba; m_addr = ba;
`else
        m_run = 0;
`endif
      end else begin
        m_addr = AW'(m_base + m_n);
      end
    end
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      for (int k = 0; k < 2; k++) begin
        if (rst_e[ecnt]) begin h_rgb[k] = '0; h_x[k] = '0; h_y[k] = '0; end
        mv = (k == 0) ? ev1[ecnt] : ev2[ecnt];
        mp = (k == 0) ? ep1[ecnt] : ep2[ecnt];
        if (mv) begin h_rgb[k] = rom_f(mp.addr); h_x[k] = mp.x; h_y[k] = mp.y; end
        mon_pix[k]  += int'(o_v[k]);
        mon_done[k] += int'(o_d[k]);
        if (o_v[k] !== mv || o_d[k] !== (mv && mp.last) || o_rgb[k] !== h_rgb[k] ||
            o_x[k] !== h_x[k] || o_y[k] !== h_y[k]) begin
          mon_bad++;
          bad_edge = ecnt; bad_k = k;
          bad_act = {o_v[k], o_d[k], o_rgb[k], o_x[k], o_y[k]};
          bad_exp = {mv, mv && mp.last, h_rgb[k], h_x[k], h_y[k]};
        end
      end
    end
  end

  task automatic drain();
    for (int i = 0; i < 4; i++) step(1, 0, 0, '0);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 0, '0);
    for (int k = 0; k < 2; k++) begin
      nchk++; if (o_a[k] !== '0) begin nerr++; $display("FAIL reset_rom_addr dut%0d: got %h want 0", k, o_a[k]); end
      nchk++; if (o_bz[k] !== 1'b0) begin nerr++; $display("FAIL reset_busy dut%0d: got %b want 0", k, o_bz[k]); end
      nchk++; if (o_v[k] !== 1'b0 || o_d[k] !== 1'b0) begin nerr++; $display("FAIL reset_valid_done dut%0d: got %b%b want 00", k, o_v[k], o_d[k]); end
      nchk++; if (o_rgb[k] !== '0) begin nerr++; $display("FAIL reset_rgb dut%0d: got %h want 0", k, o_rgb[k]); end
      nchk++; if (o_x[k] !== '0 || o_y[k] !== '0) begin nerr++; $display("FAIL reset_xy dut%0d: got %0d,%0d want 0,0", k, o_x[k], o_y[k]); end
    end
    mon_on = 1;
  endtask

  task automatic test_basic();
    int p0 [2], dn0 [2], bad0;
    for (int k = 0; k < 2; k++) begin p0[k] = mon_pix[k]; dn0[k] = mon_done[k]; end
    bad0 = mon_bad;
    step(1, 1, 1, 10'h010);  // start + pix_en together: load only
    nchk++; if (a1 !== 10'h010 || bz1 !== 1'b1) begin nerr++; $display("FAIL basic_load: got addr %h busy %b want 010 1", a1, bz1); end
    for (int i = 0; i < N; i++) begin
      nchk++; if (a1 !== AW'(16 + i) || a2 !== AW'(16 + i)) begin nerr++; $display("FAIL basic_addr%0d: got %h/%h want %h", i, a1, a2, 16 + i); end
      step(1, 0, 1, 10'h010);
      nchk++; if (v1 !== (i >= 1) || v2 !== (i >= 2)) begin nerr++; $display("FAIL basic_latency%0d: got %b%b want %b%b", i, v1, v2, i >= 1, i >= 2); end
      if (i == N - 2) begin nchk++; if (bz1 !== 1'b1) begin nerr++; $display("FAIL basic_busy_mid: got %b want 1", bz1); end end
    end
    nchk++; if (bz1 !== m_run || a1 !== m_addr) begin nerr++; $display("FAIL basic_end: got busy %b addr %h want %b %h", bz1, a1, m_run, m_addr); end
    step(1, 0, 0, '0);
    nchk++; if (d1 !== 1'b1 || x1 !== 16'd3 || y1 !== 16'd1) begin nerr++; $display("FAIL basic_done1: got d%b x%0d y%0d want d1 x3 y1", d1, x1, y1); end
    step(1, 0, 0, '0);
    nchk++; if (d2 !== 1'b1 || d1 !== 1'b0 || x2 !== 16'd3 || y2 !== 16'd1) begin nerr++; $display("FAIL basic_done2: got d%b%b x%0d y%0d want d10 x3 y1", d2, d1, x2, y2); end
    drain();
    for (int k = 0; k < 2; k++) begin
      nchk++; if (mon_pix[k] - p0[k] !== N || mon_done[k] - dn0[k] !== 1) begin nerr++; $display("FAIL basic_counts dut%0d: got %0d px %0d done want 8 1", k, mon_pix[k] - p0[k], mon_done[k] - dn0[k]); end
    end
    nchk++; if (mon_bad !== bad0) begin nerr++; $display("FAIL basic_stream: dut%0d edge %0d got %h want %h", bad_k, bad_edge, bad_act, bad_exp); end
  endtask

  task automatic test_toggle();
    int p0, bad0;
    p0 = mon_pix[0]; bad0 = mon_bad;
    step(1, 1, 0, 10'h020);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, (i % 2) == 0, 10'h020);
      if (i >= 1) begin nchk++; if (v1 !== ((i - 1) % 2 == 0)) begin nerr++; $display("FAIL toggle_v1_%0d: got %b want %b", i, v1, (i - 1) % 2 == 0); end end
      if (i >= 2) begin nchk++; if (v2 !== ((i - 2) % 2 == 0)) begin nerr++; $display("FAIL toggle_v2_%0d: got %b want %b", i, v2, (i - 2) % 2 == 0); end end
    end
    drain();
    nchk++; if (mon_pix[0] - p0 !== N) begin nerr++; $display("FAIL toggle_count: got %0d want 8", mon_pix[0] - p0); end
    nchk++; if (mon_bad !== bad0) begin nerr++; $display("FAIL toggle_stream: dut%0d edge %0d got %h want %h", bad_k, bad_edge, bad_act, bad_exp); end
  endtask

  task automatic test_abort();
    int p0, dn0, bad0;
    p0 = mon_pix[1]; dn0 = mon_done[1]; bad0 = mon_bad;
    step(1, 1, 0, 10'h010);
    for (int i = 0; i < 4; i++) step(1, 0, 1, 10'h010);
    step(1, 1, 1, 10'h040);
    nchk++; if (a1 !== 10'h040 || a2 !== 10'h040 || bz1 !== 1'b1) begin nerr++; $display("FAIL abort_jump: got %h/%h busy %b want 040 1", a1, a2, bz1); end
    for (int i = 0; i < N; i++) step(1, 0, 1, 10'h040);
    drain();
    nchk++; if (mon_pix[1] - p0 !== 4 + N || mon_done[1] - dn0 !== 1) begin nerr++; $display("FAIL abort_counts: got %0d px %0d done want 12 1", mon_pix[1] - p0, mon_done[1] - dn0); end
    nchk++; if (mon_bad !== bad0) begin nerr++; $display("FAIL abort_stream: dut%0d edge %0d got %h want %h", bad_k, bad_edge, bad_act, bad_exp); end
  endtask

  task automatic test_reset_mid();
    int p0 [2], bad0;
    step(1, 1, 0, 10'h030);
    for (int i = 0; i < 3; i++) step(1, 0, 1, 10'h030);
    step(0, 0, 1, 10'h030);
    for (int k = 0; k < 2; k++) begin
      nchk++; if (o_a[k] !== '0 || o_bz[k] !== 1'b0 || o_v[k] !== 1'b0 || o_d[k] !== 1'b0) begin nerr++; $display("FAIL rstmid_ctrl dut%0d: got addr %h busy %b v %b d %b want all 0", k, o_a[k], o_bz[k], o_v[k], o_d[k]); end
      nchk++; if (o_rgb[k] !== '0 || o_x[k] !== '0 || o_y[k] !== '0) begin nerr++; $display("FAIL rstmid_data dut%0d: got %h %0d %0d want 0", k, o_rgb[k], o_x[k], o_y[k]); end
      p0[k] = mon_pix[k];
    end
    bad0 = mon_bad;
    for (int i = 0; i < 6; i++) step(1, 0, 1, 10'h030);
    for (int k = 0; k < 2; k++) begin
      nchk++; if (mon_pix[k] !== p0[k] || o_bz[k] !== 1'b0) begin nerr++; $display("FAIL rstmid_quiet dut%0d: got %0d px busy %b want 0 0", k, mon_pix[k] - p0[k], o_bz[k]); end
    end
    nchk++; if (mon_bad !== bad0) begin nerr++; $display("FAIL rstmid_stream: dut%0d edge %0d got %h want %h", bad_k, bad_edge, bad_act, bad_exp); end
  endtask

  task automatic test_random();
    int p0, dn0, bad0, f0, guard;
    logic [AW-1:0] bs;
    for (int f = 0; f < 4; f++) begin
      p0 = mon_pix[0]; dn0 = mon_done[1]; bad0 = mon_bad;
      bs = AW'($urandom_range(0, 1000));
      step(1, 1, 1'($urandom_range(0, 1)), bs);
      f0 = m_fetch; guard = 0;
      while (m_fetch - f0 < N && guard < 300) begin
        nchk++; if (a1 !== m_addr || a2 !== m_addr || bz1 !== m_run) begin nerr++; $display("FAIL rand%0d_addr: got %h/%h busy %b want %h %b", f, a1, a2, bz1, m_addr, m_run); end
        step(1, 0, $urandom_range(0, 3) != 0, bs);
        guard++;
      end
      nchk++; if (guard >= 300) begin nerr++; $display("FAIL rand%0d_timeout: got %0d fetches want 8", f, m_fetch - f0); end
      nchk++; if (bz1 !== m_run || a1 !== m_addr) begin nerr++; $display("FAIL rand%0d_end: got busy %b addr %h want %b %h", f, bz1, a1, m_run, m_addr); end
      drain();
      nchk++; if (mon_pix[0] - p0 !== N || mon_done[1] - dn0 !== 1) begin nerr++; $display("FAIL rand%0d_counts: got %0d px %0d done want 8 1", f, mon_pix[0] - p0, mon_done[1] - dn0); end
      nchk++; if (mon_bad !== bad0) begin nerr++; $display("FAIL rand%0d_stream: dut%0d edge %0d got %h want %h", f, bad_k, bad_edge, bad_act, bad_exp); end
    end
  endtask

`ifdef ROM_FRAME_STREAMER_LOOP_EN
  task automatic test_loop();
    int p0, dn0, bad0;
    p0 = mon_pix[0]; dn0 = mon_done[0]; bad0 = mon_bad;
    step(1, 1, 0, 10'h010);
    for (int i = 0; i < 3 * N; i++) begin
      nchk++; if (a1 !== AW'(16 + i % N) || bz1 !== 1'b1) begin nerr++; $display("FAIL loop_addr%0d: got %h busy %b want %h 1", i, a1, bz1, 16 + i % N); end
      step(1, 0, 1, 10'h010);
    end
    drain();
    nchk++; if (mon_pix[0] - p0 !== 3 * N || mon_done[0] - dn0 !== 3) begin nerr++; $display("FAIL loop_counts: got %0d px %0d done want 24 3", mon_pix[0] - p0, mon_done[0] - dn0); end
    nchk++; if (mon_bad !== bad0) begin nerr++; $display("FAIL loop_stream: dut%0d edge %0d got %h want %h", bad_k, bad_edge, bad_act, bad_exp); end
  endtask
`endif

  initial begin
    rst_n = 1'b0; start = 1'b0; pix_en = 1'b0; base_addr = '0;
    test_reset();
    test_basic();
    test_toggle();
    test_abort();
    test_reset_mid();
    test_random();
`ifdef ROM_FRAME_STREAMER_LOOP_EN
    test_loop();
`endif
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/rom_frame_streamer.md
ROM_FRAME_STREAMER -- requirements
Module: rom_frame_streamer

Interface
REQ-001 The block SHALL have parameter IMG_W, default 800: image width in pixels, at least 1.
REQ-002 The block SHALL have parameter IMG_H, default 600: image height in lines, at least 1.
REQ-003 The block SHALL have parameter ADDR_W, default 19: ROM address width, with 2^ADDR_W >= base_addr + IMG_W*IMG_H.
REQ-004 The block SHALL have parameter CH_W, default 4: bits per colour channel; ROM word width is 3*CH_W, packed {r,g,b}.
REQ-005 The block SHALL have parameter ROM_LAT, default 1: ROM read latency in clocks, legal values 1 or 2.
REQ-006 The block SHALL have port clk, input, 1 bit: sole clock; all logic is on the rising edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-008 The block SHALL have port start, input, 1 bit: one-cycle request to begin a frame.
REQ-009 The block SHALL have port pix_en, input, 1 bit: pixel strobe; one ROM fetch is issued per cycle in which it is high.
REQ-010 The block SHALL have port base_addr, input, ADDR_W bits: ROM address of pixel (0,0), sampled on the start acceptance cycle.
REQ-011 The block SHALL have port rom_addr, output, ADDR_W bits: registered ROM address.
REQ-012 The block SHALL have port rom_data, input, 3*CH_W bits: ROM read data.
REQ-013 The block SHALL have ports r, g and b, output, CH_W bits each: registered pixel colour.
REQ-014 The block SHALL have ports pix_x and pix_y, output, 16 bits each: coordinates of the pixel currently on r/g/b.
REQ-015 The block SHALL have port pix_valid, output, 1 bit: r/g/b/pix_x/pix_y hold a new pixel this cycle.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in RUN.
REQ-017 The block SHALL have port frame_done, output, 1 bit: one-cycle pulse coinciding with pix_valid of the last pixel.

Function
REQ-018 The FSM SHALL have states IDLE and RUN; from IDLE, start=1 moves to RUN, loads x=y=0 and sets rom_addr=base_addr.
REQ-019 In RUN, each cycle with pix_en=1 SHALL issue the fetch at rom_addr and then advance: x+1, or x=0 and y+1 when x=IMG_W-1; rom_addr+1.
REQ-020 rom_addr SHALL be generated by incremental addition only; no multiplier.
REQ-021 The fetch at x=IMG_W-1, y=IMG_H-1 (address base_addr+IMG_W*IMG_H-1) SHALL be the last fetch of the frame; the FSM then returns to IDLE and rom_addr holds.
REQ-022 In cycles with pix_en=0 the counters and rom_addr SHALL hold, and no fetch is issued.
REQ-023 A valid/x/y tag pipeline of depth ROM_LAT SHALL follow each fetch; exactly ROM_LAT+1 cycles after the fetch cycle, pix_valid=1 and r/g/b equal rom_data for that address.
REQ-024 Outputs r/g/b/pix_x/pix_y SHALL hold their value when pix_valid=0.
REQ-025 start asserted while in RUN SHALL abort the frame and restart at (0,0) with the newly sampled base_addr; in-flight pixels still emerge, and frame_done is not pulsed for the aborted frame.
REQ-026 start and pix_en high in the same IDLE cycle SHALL only load the frame; the first fetch occurs on the next pix_en cycle.
REQ-027 For IMG_W=IMG_H=1, the frame SHALL be a single fetch, with frame_done on its pix_valid.
REQ-028 busy SHALL fall in the cycle after the last fetch.

Reset
REQ-029 When rst_n=0 at a clock edge: state=IDLE, rom_addr=0, counters=0, tag pipeline cleared, r/g/b=0, pix_x=pix_y=0, pix_valid=0, busy=0, frame_done=0.
REQ-030 Reset mid-frame SHALL discard all in-flight pixels; no pix_valid is asserted until after a new start.

Configuration
REQ-031 With macro ROM_FRAME_STREAMER_LOOP_EN defined, the block SHALL re-sample base_addr after the last fetch and continue in RUN at (0,0) with no gap, and busy SHALL stay high.
REQ-032 Without ROM_FRAME_STREAMER_LOOP_EN, the block SHALL return to IDLE after each frame and wait for start.

Verification
REQ-033 Scenario: IMG_W=4, IMG_H=2, ROM_LAT=1, base=0x10, pix_en=1 -> rom_addr steps 0x10 to 0x17; 8 pix_valid pulses; frame_done with pix_x=3, pix_y=1; then busy=0.
REQ-034 Scenario: pix_en toggling 1,0,1,0 -> pix_valid gaps mirror pix_en delayed by 2 cycles; data matches the ROM model at every valid.
REQ-035 Scenario: ROM_LAT=2 -> first pix_valid 3 cycles after the first fetch; 8 pixels correct.
REQ-036 Scenario: start at the 5th fetch, new base=0x40 -> rom_addr jumps to 0x40; next frame completes with one frame_done.
REQ-037 Scenario: rst_n=0 for 1 cycle mid-frame -> all outputs 0 next cycle; no pix_valid until start.
REQ-038 Scenario: LOOP_EN defined, 3 frames -> rom_addr wraps 0x17 to 0x10 with no idle cycle; 3 frame_done pulses, each 8 pixels apart.
